action_encoder: RTL and testbench

ACTION_ENCODER -- requirements
Module: action_encoder

---
 rtl/action_encoder.sv | 101 ++++++++++
 tb/tb_action_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/action_encoder.sv
// Debounced push-button to one-hot action pulse encoder.
// Emits one registered pulse per press; suppressed while the game is won.
module action_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [1:0] game_status,
  output logic [3:0] act,
  output logic       active,
  output logic [7:0] pulse_cnt
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] WINNED = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    FIRE,
    RELEASE
  } state_t;

  state_t        state;
  logic [3:0]    sync1;
  logic [3:0]    btn_s;
  logic [1:0]    idx;
  logic [1:0]    low_idx;
  logic [CW-1:0] cnt;

  // lowest set bit wins on simultaneous presses
  always_comb begin
    low_idx = 2'd0;
    priority case (1'b1)
      btn_s[0]: low_idx = 2'd0;
      btn_s[1]: low_idx = 2'd1;
      btn_s[2]: low_idx = 2'd2;
      btn_s[3]: low_idx = 2'd3;
      default:  low_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      btn_s     <= '0;
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      act       <= '0;
      active    <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      sync1  <= btn;
      btn_s  <= sync1;
      act    <= '0;
      active <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s != 4'd0) begin
            idx   <= low_idx;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!btn_s[idx]) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= FIRE;
            if (game_status != WINNED) begin
              act       <= 4'b0001 << idx;
              active    <= 1'b1;
              pulse_cnt <= pulse_cnt + 8'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIRE: begin
          cnt   <= '0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (btn_s != 4'd0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_encoder.sv
// Scoreboard bench for action_encoder: a press-level reference model
// predicts each cycle's outputs; a monitor checks them on the falling edge.
module tb_action_encoder;

  localparam int D = 4;

  typedef struct packed {
    logic [3:0] act;
    logic       active;
    logic [7:0] pcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [1:0] game_status = 2'b01;
  logic [3:0] act;
  logic       active;
  logic [7:0] pulse_cnt;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  action_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .game_status(game_status),
    .act(act),
    .active(active),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the press being qualified, the pulse,
  // and the run of all-released samples needed before re-arming.
  initial begin
    logic [3:0] s1, s2, s;
    logic [7:0] pcnt;
    bit         tracking, fired, releasing;
    int         held, zeros, midx;
    exp_t       e;
    s1 = '0; s2 = '0; pcnt = '0;
    tracking = 0; fired = 0; releasing = 0;
    held = 0; zeros = 0; midx = 0;
    forever begin
      @(posedge clk);
      e = '0;
      if (!reset) begin
        s1 = '0; s2 = '0; pcnt = '0;
        tracking = 0; fired = 0; releasing = 0;
      end else begin
        s = s2;
        s2 = s1;
        s1 = btn;
        if (fired) begin
          fired = 0;
          releasing = 1;
          zeros = 0;
        end else if (releasing) begin
          zeros = (s == 4'd0) ? zeros + 1 : 0;
          if (zeros == D) releasing = 0;
        end else if (tracking) begin
          if (!s[midx]) begin
            tracking = 0;
          end else begin
            held++;
            if (held == D) begin
              tracking = 0;
              fired = 1;
              if (game_status != 2'b11) begin
                e.act = 4'd1 << midx;
                e.active = 1'b1;
                pcnt = pcnt + 8'd1;
              end
            end
          end
        end else if (s != 4'd0) begin
          tracking = 1;
          held = 0;
          for (int i = 3; i >= 0; i--)
            if (s[i]) midx = i;
        end
      end
      e.pcnt = pcnt;
      q.push_back(e);
    end
  end

  // Monitor: one comparison per cycle, asynchronous reset forces zeros.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = q.pop_front();
        if (!reset) e = '0;
        if ({act, active, pulse_cnt} !== e) begin
          fails++;
          $display({"FAIL cycle_out t=%0t act=%b active=%b cnt=%0d",
                    " expected act=%b active=%b cnt=%0d"},
                   $time, act, active, pulse_cnt,
                   e.act, e.active, e.pcnt);
        end
      end
    end
  end

  task automatic step(input logic [3:0] b, input logic [1:0] g,
                      input int n);
    btn = b;
    game_status = g;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    tests++;
    if (act !== 4'd0 || active !== 1'b0 || pulse_cnt !== 8'd0) begin
      fails++;
      $display("FAIL async_reset act=%b active=%b cnt=%0d expected 0",
               act, active, pulse_cnt);
    end
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] m;
    @(posedge clk);
    #2;
    step(4'd0, 2'b01, 3);
    reset = 1'b1;
    step(4'd0, 2'b01, 2);
    // single press at full latency
    step(4'b0001, 2'b01, 12);
    step(4'd0, 2'b01, 8);
    // glitch rejected
    step(4'b0100, 2'b01, 2);
    step(4'd0, 2'b01, 8);
    // simultaneous press, held: one pulse, re-arm needs D zero samples
    step(4'b1010, 2'b01, 20);
    step(4'd0, 2'b01, 3);
    step(4'b1010, 2'b01, 10);
    step(4'd0, 2'b01, 8);
    step(4'b1010, 2'b01, 10);
    step(4'd0, 2'b01, 8);
    // suppressed while won, then accepted
    step(4'b1000, 2'b11, 12);
    step(4'd0, 2'b11, 8);
    step(4'b1000, 2'b01, 12);
    step(4'd0, 2'b01, 8);
    // reset during debounce, button still held afterwards
    step(4'b0001, 2'b01, 4);
    do_reset(2);
    step(4'b0001, 2'b01, 12);
    step(4'd0, 2'b01, 8);
    // reset in the pulse cycle
    step(4'b0010, 2'b01, 7);
    do_reset(1);
    step(4'b0010, 2'b01, 12);
    step(4'd0, 2'b01, 8);
    // game_status wandering outside the fire edge
    step(4'b0100, 2'b11, 3);
    step(4'b0100, 2'b00, 3);
    step(4'b0100, 2'b10, 4);
    step(4'd0, 2'b11, 8);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      m = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(m, 2'($urandom), $urandom_range(1, 12));
      if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 3));
    end
    // counter wrap: 257 pulses after reset
    step(4'd0, 2'b01, 2);
    do_reset(2);
    for (int i = 0; i < 257; i++) begin
      step(4'($urandom_range(1, 15)), 2'($urandom_range(0, 2)), 8);
      step(4'd0, 2'b01, 6);
    end
    step(4'd0, 2'b01, 2);
    @(negedge clk);
    #1;
    tests++;
    if (pulse_cnt !== 8'd1) begin
      fails++;
      $display("FAIL wrap_count cnt=%0d expected 1", pulse_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
